// File: rtl/serial_receiver.sv
// 8N1 serial receiver with a two-flop input synchronizer and a show-ahead byte FIFO.
// Framing errors and dropped bytes are reported as single-cycle pulses.
module serial_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       sysclk_i,
    input  logic       reset_ni,
    input  logic       serial_in_i,
    input  logic       rd_en_i,
    output logic [7:0] data_out_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LastTick = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfTick = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        sync1_q, rx_s_q, rx_prev_q;
    logic        push, frame_err_d;

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        frame_err_q, overflow_q;
    logic        pop, wr_en, overflow_d, empty, full;

    // Synchronizer idles high so a reset never fakes a start edge by itself.
    always_ff @(posedge sysclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= serial_in_i;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge sysclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = StStart;
                    timer_d = '0;
                end
            end
            StStart: begin
                if (timer_q == HalfTick) begin
                    timer_d = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StData: begin
                if (timer_q == LastTick) begin
                    timer_d         = '0;
                    shift_d[idx_q]  = rx_s_q;
                    idx_d           = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StStop: begin
                if (timer_q == LastTick) begin
                    timer_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = rd_en_i && !empty;
    assign wr_en      = push && (!full || pop);
    assign overflow_d = push && full && !pop;

    always_ff @(posedge sysclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
                wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    assign data_out_o  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o     = empty;
    assign full_o      = full;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = (state_q != StIdle);

endmodule
